// File: rtl/mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_arbiter
// Description : Round-robin arbiter sharing one Avalon-MM master between the
//               instruction-fetch port and the load/store port.
// Revision    : 1.0 - initial release
// ============================================================================

module mips_cpu_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        bus_error
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BUS   = 2'd1;
  localparam logic [1:0] c_RDATA = 2'd2;
  localparam logic [1:0] c_ACK   = 2'd3;

  localparam logic c_PORT_I = 1'b0;
  localparam logic c_PORT_D = 1'b1;

  localparam logic [7:0] c_STALL_LIMIT = 8'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        wr_q, wr_d;
  logic [7:0]  stall_q, stall_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_error_q, bus_error_d;

  logic        w_d_req;
  logic        w_any_req;
  logic        w_pick;
  logic [7:0]  w_stall_inc;
  logic        w_abort;

  assign w_d_req   = d_read | d_write;
  assign w_any_req = i_req | w_d_req;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    w_pick = c_PORT_I;
    if (i_req && w_d_req) begin
      w_pick = (last_grant_q == c_PORT_D) ? c_PORT_I : c_PORT_D;
    end else if (w_d_req) begin
      w_pick = c_PORT_D;
    end
  end

  assign w_stall_inc = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
  assign w_abort     = waitrequest && (w_stall_inc >= c_STALL_LIMIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= c_PORT_D;
      grant_q      <= c_PORT_I;
      wr_q         <= 1'b0;
      stall_q      <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      bus_error_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      stall_q      <= stall_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_any_req) begin
          state_d = c_BUS;
        end
      end
      c_BUS: begin
        if (waitrequest) begin
          if (w_abort) begin
            state_d = c_ACK;
          end
        end else begin
          state_d = wr_q ? c_ACK : c_RDATA;
        end
      end
      c_RDATA: state_d = c_ACK;
      c_ACK:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    stall_d      = stall_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    bus_error_d  = bus_error_q;
    case (state_q)
      c_IDLE: begin
        if (w_any_req) begin
          grant_d      = w_pick;
          last_grant_d = w_pick;
          stall_d      = 8'd0;
          if (w_pick == c_PORT_D) begin
            wr_d    = d_write;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            be_d    = d_byteenable;
          end else begin
            wr_d    = 1'b0;
            addr_d  = i_addr;
            be_d    = 4'hF;
          end
        end
      end
      c_BUS: begin
        if (waitrequest) begin
          stall_d = w_stall_inc;
          // Watchdog abort still completes the transaction with zero data.
          if (w_abort) begin
            bus_error_d = 1'b1;
            if (grant_q == c_PORT_D) begin
              d_rdata_d = 32'd0;
            end else begin
              i_rdata_d = 32'd0;
            end
          end
        end
      end
      c_RDATA: begin
        if (grant_q == c_PORT_D) begin
          d_rdata_d = readdata;
        end else begin
          i_rdata_d = readdata;
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    read  = 1'b0;
    write = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b0;
    busy  = (state_q != c_IDLE);
    case (state_q)
      c_BUS: begin
        read  = ~wr_q;
        write = wr_q;
      end
      c_ACK: begin
        i_ack = (grant_q == c_PORT_I);
        d_ack = (grant_q == c_PORT_D);
      end
      default: begin
      end
    endcase
  end

  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign bus_error  = bus_error_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_bus_arbiter
// Description : Vector table, corner sequences and random traffic against a
//               transaction-level model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mips_cpu_bus_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_byteenable = 4'd0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        busy;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  // Model state: port that won last (1 = data port) and sticky error.
  logic m_last;
  logic m_err;

  mips_cpu_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_byteenable (d_byteenable),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .busy         (busy),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        dw;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  be;
    int          stalls;
    logic [31:0] rd;
    logic        e_port;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_chk;
    logic [31:0] e_data;
    int          e_strb;
    int          e_lat;
    logic        e_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // Acts as the Avalon slave for one transaction and checks it end to end.
  // Entered and left just after a falling edge.
  task automatic complete_one(
    input string       nm,
    input int          stalls,
    input logic [31:0] rd,
    input logic        exp_port,
    input logic        exp_wr,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic        chk_data,
    input logic [31:0] exp_data,
    input int          exp_strobes,
    input int          exp_lat,
    input logic        exp_err
  );
    int   cyc;
    int   strobes;
    int   first;
    int   ack_cyc;
    logic acc;
    cyc = 0; strobes = 0; first = -1; ack_cyc = -1; acc = 1'b0;
    waitrequest = 1'b1;
    while (ack_cyc < 0 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      readdata = acc ? rd : $urandom;
      acc = 1'b0;
      if (read || write) begin
        strobes++;
        if (first < 0) first = cyc;
        chk({nm, " read"}, 32'(read), 32'(!exp_wr));
        chk({nm, " write"}, 32'(write), 32'(exp_wr));
        chk({nm, " address"}, address, exp_addr);
        chk({nm, " byteenable"}, 32'(byteenable), 32'(exp_be));
        if (exp_wr) chk({nm, " writedata"}, writedata, exp_wdata);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        waitrequest = (strobes <= stalls);
        acc = !waitrequest;
      end
      if (i_ack || d_ack) begin
        ack_cyc = cyc;
        chk({nm, " ack port"}, {30'd0, d_ack, i_ack}, exp_port ? 32'd2 : 32'd1);
        if (chk_data) chk({nm, " rdata"}, exp_port ? d_rdata : i_rdata, exp_data);
        chk({nm, " bus_error"}, 32'(bus_error), 32'(exp_err));
        if (i_ack) i_req = 1'b0;
        if (d_ack) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end
      end
    end
    chk({nm, " ack seen"}, 32'(ack_cyc >= 0), 32'd1);
    chk({nm, " issue cycle"}, 32'(first), 32'd1);
    chk({nm, " strobe cycles"}, 32'(strobes), 32'(exp_strobes));
    chk({nm, " ack latency"}, 32'(ack_cyc - first), 32'(exp_lat));
    waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " ack pulse end"}, {30'd0, d_ack, i_ack}, 32'd0);
    chk({nm, " idle after ack"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    //          ir    dr    dw    ia            da            wd            be    st rd            port  wr    addr          ebe   chk   data          strb lat err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hBFC00000, 32'h0,       32'h0,        4'h0, 0, 32'h3C020005, 1'b0, 1'b0, 32'hBFC00000, 4'hF, 1'b1, 32'h3C020005, 1, 2, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,       32'h00001000, 32'hDEADBEEF, 4'h3, 3, 32'h0,        1'b1, 1'b1, 32'h00001000, 4'h3, 1'b0, 32'h0,        4, 4, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h100,     32'h200,      32'h0,        4'hF, 0, 32'h11111111, 1'b0, 1'b0, 32'h100,      4'hF, 1'b1, 32'h11111111, 1, 2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h104,     32'h200,      32'h0,        4'hF, 1, 32'h22222222, 1'b1, 1'b0, 32'h200,      4'hF, 1'b1, 32'h22222222, 2, 3, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h104,     32'h204,      32'h0,        4'hF, 0, 32'h33333333, 1'b0, 1'b0, 32'h104,      4'hF, 1'b1, 32'h33333333, 1, 2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h108,     32'h204,      32'h0,        4'hF, 2, 32'h44444444, 1'b1, 1'b0, 32'h204,      4'hF, 1'b1, 32'h44444444, 3, 4, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h108,     32'h0,        32'h0,        4'h0, 0, 32'h66666666, 1'b0, 1'b0, 32'h108,      4'hF, 1'b1, 32'h66666666, 1, 2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0,       32'h300,      32'hCAFEF00D, 4'hC, 1, 32'h0,        1'b1, 1'b1, 32'h300,      4'hC, 1'b0, 32'h0,        2, 2, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h400,      32'h0,        4'hF, 4, 32'h77777777, 1'b1, 1'b0, 32'h400,      4'hF, 1'b1, 32'h0,        4, 4, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h500,     32'h0,        32'h0,        4'h0, 0, 32'h55555555, 1'b0, 1'b0, 32'h500,      4'hF, 1'b1, 32'h55555555, 1, 2, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,       32'h600,      32'h12345678, 4'h1, 9, 32'h0,        1'b1, 1'b1, 32'h600,      4'h1, 1'b1, 32'h0,        4, 4, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst address", address, 32'd0);
    chk("rst read", 32'(read), 32'd0);
    chk("rst write", 32'(write), 32'd0);
    chk("rst writedata", writedata, 32'd0);
    chk("rst byteenable", 32'(byteenable), 32'd0);
    chk("rst i_ack", 32'(i_ack), 32'd0);
    chk("rst d_ack", 32'(d_ack), 32'd0);
    chk("rst i_rdata", i_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bus_error", 32'(bus_error), 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 11; k++) begin
      i_req        = vecs[k].ir;
      d_read       = vecs[k].dr;
      d_write      = vecs[k].dw;
      i_addr       = vecs[k].ia;
      d_addr       = vecs[k].da;
      d_wdata      = vecs[k].wd;
      d_byteenable = vecs[k].be;
      complete_one($sformatf("vec%0d", k), vecs[k].stalls, vecs[k].rd,
                   vecs[k].e_port, vecs[k].e_wr, vecs[k].e_addr, vecs[k].e_be,
                   vecs[k].wd, vecs[k].e_chk, vecs[k].e_data,
                   vecs[k].e_strb, vecs[k].e_lat, vecs[k].e_err);
    end

    // Reset asserted in the middle of a stalled load
    d_read       = 1'b1;
    d_addr       = 32'h700;
    d_byteenable = 4'hF;
    waitrequest  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst read before", 32'(read), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst read", 32'(read), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst bus_error", 32'(bus_error), 32'd0);
    chk("midrst address", address, 32'd0);
    d_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst no ack", {30'd0, d_ack, i_ack}, 32'd0);
      chk("midrst idle", 32'(busy), 32'd0);
    end
    reset       = 1'b1;
    waitrequest = 1'b0;
    i_req       = 1'b1;
    i_addr      = 32'h800;
    complete_one("post reset fetch", 0, 32'h88888888, 1'b0, 1'b0, 32'h800, 4'hF,
                 32'h0, 1'b1, 32'h88888888, 1, 2, 1'b0);
    m_last = 1'b0;
    m_err  = 1'b0;

    // Random traffic against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      logic        win;
      logic        ewr;
      logic        abort;
      int          st;
      int          ns;
      int          kind;
      logic [31:0] rd;
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
        kind         = int'($urandom_range(0, 2));
        d_read       = (kind != 1);
        d_write      = (kind != 0);
        d_addr       = $urandom;
        d_wdata      = $urandom;
        d_byteenable = 4'($urandom_range(1, 15));
      end
      if (!i_req && !d_read && !d_write) begin
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFFFFFC;
      end
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      rd = $urandom;

      win   = (i_req && (d_read || d_write)) ? !m_last : (d_read || d_write);
      ewr   = win && d_write;
      abort = (st >= MAX_WAIT);
      ns    = abort ? MAX_WAIT : st + 1;
      m_err = m_err | abort;
      complete_one($sformatf("rnd%0d", n), st, rd, win, ewr,
                   win ? d_addr : i_addr, win ? d_byteenable : 4'hF, d_wdata,
                   !ewr || abort, abort ? 32'h0 : rd, ns,
                   (abort || ewr) ? ns : ns + 1, m_err);
      m_last = win;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
